// File: rtl/ahb_master_pkg.sv
// Shared types and constants for the AHB-lite master front end.
package ahb_master_pkg;

    // Front-end sequencing: wait for command, request bus, address phase, data phase.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ADDR = 2'd2,
        S_DATA = 2'd3
    } state_e;

    // Only single, non-burst transfers are ever issued.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // One-hot slave select from the two top address bits; bits [3:2] are the bridge slaves.
    function automatic logic [3:0] sel_decode(input logic [1:0] top);
        logic [3:0] sel;
        case (top)
            2'b00:   sel = 4'b0001;
            2'b01:   sel = 4'b0010;
            2'b10:   sel = 4'b0100;
            default: sel = 4'b1000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ahb_grant_timer.sv
// Counts cycles spent waiting for an arbiter grant and flags when the wait
// budget is used up. A budget of 0 means wait forever.
module ahb_grant_timer #(
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    if (GRANT_TIMEOUT == 0) begin : g_off
        assign expired_o = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(GRANT_TIMEOUT + 1);
        localparam logic [CW-1:0] CNT_MAX  = CW'(GRANT_TIMEOUT);
        // Expiry is flagged during the last permitted waiting cycle so the
        // request is held for exactly GRANT_TIMEOUT cycles.
        localparam logic [CW-1:0] CNT_LAST = CW'(GRANT_TIMEOUT - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Next count: clear wins, otherwise count up and saturate at the budget.
        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (enable_i && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Count register.
        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_o = enable_i && (cnt_q >= CNT_LAST);
    end

endmodule

// File: rtl/ahb_master_if.sv
// Single-outstanding AHB-lite master front end. Takes one command from local
// logic, requests the bus from the arbiter, runs address and data phases and
// returns a one-cycle response pulse with read data and error status.
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle. The response
// side has no backpressure: rsp_valid is a single-cycle pulse.
module ahb_master_if
    import ahb_master_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              hreq,
    input  logic              hgrant,
    output logic [3:0]        sel,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output state_e            dbg_state_o
);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                hreq_q;
    logic [3:0]          sel_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic                hwrite_q;
    logic [1:0]          htrans_q;
    logic [DATA_W-1:0]   hwdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                grant_expired;

    // The grant timer runs only while requesting and restarts on every entry to S_REQ.
    ahb_grant_timer #(
        .GRANT_TIMEOUT (GRANT_TIMEOUT)
    ) u_grant_timer (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .clear_i   (state_q != S_REQ),
        .enable_i  (state_q == S_REQ),
        .expired_o (grant_expired)
    );

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            hreq_q      <= 1'b0;
            sel_q       <= 4'b0000;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        write_q <= cmd_write;
                        wdata_q <= cmd_wdata;
                        sel_q   <= sel_decode(cmd_addr[ADDR_W-1 -: 2]);
                        hreq_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (hgrant) begin
                        haddr_q  <= addr_q;
                        hwrite_q <= write_q;
                        htrans_q <= HTRANS_NONSEQ;
                        state_q  <= S_ADDR;
                    end else if (grant_expired) begin
                        // Give up on the bus: report an error without any bus activity.
                        hreq_q      <= 1'b0;
                        sel_q       <= 4'b0000;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (!hgrant) begin
                        // Lost the bus before the address was taken: retract and re-request.
                        htrans_q <= HTRANS_IDLE;
                        state_q  <= S_REQ;
                    end else if (hready) begin
                        htrans_q <= HTRANS_IDLE;
                        if (write_q) begin
                            hwdata_q <= wdata_q;
                        end
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Grant is irrelevant once the address phase has been accepted.
                    if (hready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= hresp;
                        if (!write_q) begin
                            rsp_rdata_q <= hrdata;
                        end
                        hreq_q  <= 1'b0;
                        sel_q   <= 4'b0000;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign hreq        = hreq_q;
    assign sel         = sel_q;
    assign haddr       = haddr_q;
    assign hwrite      = hwrite_q;
    assign htrans      = htrans_q;
    assign hwdata      = hwdata_q;
    assign dbg_state_o = state_q;

endmodule
